parity_checker: RTL and testbench

Receive-side counterpart to the ALU datapath's parity generator. Accepts a stream of {opcode, 4-bit result, parity bit} beats and pipelines them through two register stages. Each beat gets an odd-parity check, and its opcode is decoded back to the one-hot 8-bit function code. Parity failures feed a saturating error counter, a sticky flag, and an alarm FSM that raises `alarm` once a threshold count is reached.

---
 rtl/parity_checker_pkg.sv | 34 +++
 rtl/parity_checker_decoder.sv | 14 +
 rtl/parity_checker.sv | 107 ++++++++++
 tb/tb_parity_checker.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/parity_checker_pkg.sv
// Shared definitions for the ALU parity path: opcodes, alarm FSM states and
// the parity function used by both the generator and this checker.
package parity_checker_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_NAND = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  localparam int NUM_OPS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALARM = 2'd2
  } state_t;

  // Odd parity: the generator emits the XNOR of the data bits so that
  // {data, parity} always carries an odd number of ones. Callers zero-extend
  // narrower words; the extra zeros do not change the reduction.
  function automatic logic gen_parity(input logic [31:0] d);
    return ~(^d);
  endfunction

  // A beat is bad when {data, parity} holds an even number of ones.
  function automatic logic parity_error(input logic [31:0] d, input logic p);
    return ~((^d) ^ p);
  endfunction

endpackage

// File: rtl/parity_checker_decoder.sv
// Opcode to one-hot function code, MSB-first: opcode k lights bit 7-k.
module opcode_decoder
  import parity_checker_pkg::*;
(
  input  logic [2:0]         opcode,
  output logic [NUM_OPS-1:0] funccode
);

  // One comparator per function-code bit.
  for (genvar k = 0; k < NUM_OPS; k++) begin : g_bit
    assign funccode[NUM_OPS-1-k] = (opcode == 3'(k));
  end

endmodule

// File: rtl/parity_checker.sv
// Receive-side parity checker: two-stage pipeline with odd-parity check and
// opcode decode, plus saturating error counter, sticky flag and alarm FSM.
module parity_checker
  import parity_checker_pkg::*;
#(
  parameter int DATA_WIDTH      = 4,
  parameter int COUNT_WIDTH     = 8,
  parameter int ALARM_THRESHOLD = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [2:0]             in_opcode,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_parity,
  input  logic                   clear,
  output logic                   out_valid,
  output logic [NUM_OPS-1:0]     out_funccode,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   out_error,
  output logic                   sticky_error,
  output logic [COUNT_WIDTH-1:0] error_count,
  output logic                   alarm
);

  localparam int STAGES = 2;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] THRESH  = COUNT_WIDTH'(ALARM_THRESHOLD);

  // vld_pipe[0] is the incoming valid, vld_pipe[s] the valid held at stage s.
  logic [STAGES:0]       vld_pipe;
  logic [STAGES:1]       vld_q;
  logic [2:0]            s1_op;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_par;
  logic [NUM_OPS-1:0]    dec_code;
  logic                  cnt_inc;
  state_t                state_q, state_d;

  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_pipe[STAGES];

  opcode_decoder u_dec (
    .opcode   (s1_op),
    .funccode (dec_code)
  );

  // Pipeline stages; reset drops anything in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      vld_q        <= '0;
      s1_op        <= '0;
      s1_data      <= '0;
      s1_par       <= 1'b0;
      out_funccode <= '0;
      out_data     <= '0;
      out_error    <= 1'b0;
    end else begin
      vld_q        <= vld_pipe[STAGES-1:0];
      s1_op        <= in_opcode;
      s1_data      <= in_data;
      s1_par       <= in_parity;
      out_funccode <= dec_code;
      out_data     <= s1_data;
      out_error    <= vld_pipe[1] & parity_error(32'(s1_data), s1_par);
    end
  end

  // Only a shown, failing beat counts, and clear overrides it.
  assign cnt_inc = out_valid & out_error & ~clear;

  // Saturating error counter and sticky flag.
  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      error_count  <= '0;
      sticky_error <= 1'b0;
    end else if (cnt_inc) begin
      sticky_error <= 1'b1;
      if (error_count != CNT_MAX) error_count <= error_count + 1'b1;
    end
  end

  // Alarm FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state: RUN watches the already-updated count, so ALARM lands one
  // cycle after the count crosses the threshold.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (out_valid) state_d = RUN;
        RUN:     if (error_count >= THRESH) state_d = ALARM;
        ALARM:   state_d = ALARM;
        default: state_d = IDLE;
      endcase
    end
  end

  assign alarm = (state_q == ALARM);

endmodule

// File: tb/tb_parity_checker.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and
// compares, and tracks counter/sticky/alarm with a behavioural model. A second
// instance with a 2-bit counter exercises saturation on the same stream.
module tb_parity_checker;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_opcode = '0;
  logic [3:0] in_data = '0;
  logic       in_parity = 1'b0;
  logic       clear = 1'b0;

  logic       a_valid, a_err, a_sticky, a_alarm;
  logic [7:0] a_code;
  logic [3:0] a_data;
  logic [7:0] a_cnt;
  logic       b_valid, b_err, b_sticky, b_alarm;
  logic [7:0] b_code;
  logic [3:0] b_data;
  logic [1:0] b_cnt;

  parity_checker #(.DATA_WIDTH(4), .COUNT_WIDTH(8), .ALARM_THRESHOLD(3)) dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_data(in_data), .in_parity(in_parity), .clear(clear),
    .out_valid(a_valid), .out_funccode(a_code), .out_data(a_data), .out_error(a_err),
    .sticky_error(a_sticky), .error_count(a_cnt), .alarm(a_alarm));

  parity_checker #(.DATA_WIDTH(4), .COUNT_WIDTH(2), .ALARM_THRESHOLD(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_data(in_data), .in_parity(in_parity), .clear(clear),
    .out_valid(b_valid), .out_funccode(b_code), .out_data(b_data), .out_error(b_err),
    .sticky_error(b_sticky), .error_count(b_cnt), .alarm(b_alarm));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    int         due;
    logic [7:0] code;
    logic [3:0] data;
    logic       err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: counts as plain integers, state as a small number.
  int m_cnt_a = 0, m_cnt_b = 0;
  bit m_sticky = 0;
  int m_state = 0;  // 0 idle, 1 running, 2 alarmed

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge; a valid beat is due
  // on the outputs two edges later.
  task automatic drive(input bit v, input int op, input int d, input bit p,
                       input bit clr, input bit rn);
    exp_t e;
    logic [7:0] top_bit;
    @(posedge clock);
    #1;
    in_valid  = v;
    in_opcode = 3'(op);
    in_data   = 4'(d);
    in_parity = p;
    clear     = clr;
    reset_n   = rn;
    if (v && rn) begin
      top_bit = 8'h80;
      e.due  = cyc + 2;
      e.code = top_bit >> op;
      e.data = 4'(d);
      e.err  = ($countones({4'(d), p}) % 2) == 0;
      q.push_back(e);
    end
  endtask

  function automatic bit good_par(input int d);
    return ($countones(4'(d)) % 2) == 0;
  endfunction

  task automatic good(input int op, input int d);
    drive(1, op, d, good_par(d), 0, 1);
  endtask

  task automatic bad(input int op, input int d);
    drive(1, op, d, ~good_par(d), 0, 1);
  endtask

  task automatic bubble(input bit clr);
    drive(0, 0, 0, 0, clr, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    @(negedge clock);
    chk({tag, "_code_a"}, 32'(a_code), 32'h0);
    chk({tag, "_data_a"}, 32'(a_data), 32'h0);
    chk({tag, "_err_a"},  32'(a_err),  32'h0);
    chk({tag, "_code_b"}, 32'(b_code), 32'h0);
  endtask

  // Monitor: compare against the scoreboard head and the model every cycle.
  always @(negedge clock) begin
    bit   hb;
    exp_t e;
    int   nxt;
    hb = (q.size() > 0) && (q[0].due == cyc);
    if (q.size() > 0 && q[0].due < cyc) begin
      chk("stale_beat", 32'(q[0].due), 32'(cyc));
      void'(q.pop_front());
    end
    chk("valid_a", 32'(a_valid), 32'(hb));
    chk("valid_b", 32'(b_valid), 32'(hb));
    if (hb) begin
      e = q.pop_front();
      chk("code_a", 32'(a_code), 32'(e.code));
      chk("data_a", 32'(a_data), 32'(e.data));
      chk("err_a",  32'(a_err),  32'(e.err));
      chk("code_b", 32'(b_code), 32'(e.code));
      chk("err_b",  32'(b_err),  32'(e.err));
    end
    chk("count_a",  32'(a_cnt),    32'(m_cnt_a));
    chk("count_b",  32'(b_cnt),    32'(m_cnt_b));
    chk("sticky_a", 32'(a_sticky), 32'(m_sticky));
    chk("sticky_b", 32'(b_sticky), 32'(m_sticky));
    chk("alarm_a",  32'(a_alarm),  32'(m_state == 2));
    chk("alarm_b",  32'(b_alarm),  32'(m_state == 2));

    // Advance the model to what the next cycle should show.
    if (!reset_n || clear) begin
      m_cnt_a = 0; m_cnt_b = 0; m_sticky = 0; m_state = 0;
    end else begin
      nxt = m_state;
      if (m_state == 0 && hb) nxt = 1;
      if (m_state == 1 && m_cnt_a >= 3) nxt = 2;
      m_state = nxt;
      if (hb && e.err) begin
        m_sticky = 1;
        m_cnt_a = (m_cnt_a + 1 > 255) ? 255 : m_cnt_a + 1;
        m_cnt_b = (m_cnt_b + 1 > 3) ? 3 : m_cnt_b + 1;
      end
    end
  end

  initial begin
    // Reset: every output idles at zero.
    repeat (2) drive(0, 0, 0, 0, 0, 0);
    check_zero_outputs("reset");
    bubble(0);

    // Single ADD beat, data 0011 with its correct parity bit 1.
    drive(1, 0, 3, 1, 0, 1);
    repeat (3) bubble(0);

    // Opcodes 0..7 back to back, all parity-correct.
    for (int k = 0; k < 8; k++) drive(1, k, 0, 1, 0, 1);
    repeat (3) bubble(0);

    // Bad beats separated by bubbles: 3 reach the threshold, 2 more
    // push the narrow counter into saturation.
    for (int k = 0; k < 5; k++) begin
      bad(k % 8, 11);
      bubble(0);
    end
    repeat (4) bubble(0);

    // Bad beat at stage 2 in the same cycle as clear, while alarmed.
    bad(2, 6);
    bubble(0);
    bubble(1);
    repeat (3) bubble(0);

    // Randomised stream with occasional clears.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0)
        drive(1, $urandom_range(0, 7), $urandom_range(0, 15), 1'($urandom_range(0, 1)),
              $urandom_range(0, 49) == 0, 1);
      else
        bubble($urandom_range(0, 49) == 0);
    end

    // Reset with two beats in flight: neither may appear.
    good(5, 9);
    drive(1, 6, 7, good_par(7), 0, 0);
    q.delete();
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check_zero_outputs("midreset");
    drive(0, 0, 0, 0, 0, 1);
    repeat (3) bubble(0);

    // A few more beats to prove recovery after reset.
    for (int i = 0; i < 20; i++)
      drive(1, $urandom_range(0, 7), $urandom_range(0, 15), 1'($urandom_range(0, 1)), 0, 1);
    repeat (4) bubble(0);

    @(negedge clock);
    chk("drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
